// File: rtl/key_entry_buffer.sv
// Keypad digit entry buffer: edge-detects key presses and the submit button,
// stores up to MAX_DIGITS codes and freezes them for the controller after submit.
// Optional feature: define KEY_BACKSPACE_EN to make code 4'hB delete the last digit.
module key_entry_buffer #(
  parameter int MAX_DIGITS = 10,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          system_reset,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic                          submit_btn,
  input  logic                          clear,
  output logic [MAX_DIGITS*DIGIT_W-1:0] digits,
  output logic [3:0]                    num_inputs,
  output logic                          submit,
  output logic                          key_accept,
  output logic                          full,
  output logic                          overflow
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_FULL  = 2'd2,
    S_HELD  = 2'd3
  } state_t;

  localparam logic [3:0]         MAX_CNT        = 4'(MAX_DIGITS);
  localparam logic [DIGIT_W-1:0] CODE_MAX_DIGIT = DIGIT_W'(9);
`ifdef KEY_BACKSPACE_EN
  localparam logic [DIGIT_W-1:0] CODE_BACKSPACE = DIGIT_W'(11);
`endif

  state_t                          state_q, state_d;
  logic [MAX_DIGITS*DIGIT_W-1:0]   digits_q, digits_d;
  logic [3:0]                      count_q, count_d;
  logic                            overflow_q, overflow_d;
  logic                            submit_q, submit_d;
  logic                            accept_q, accept_d;
  logic                            key_valid_q, submit_btn_q;
  logic                            press;
  logic                            submit_edge;

  assign press       = key_valid & ~key_valid_q;
  assign submit_edge = submit_btn & ~submit_btn_q;

  // State and datapath registers; edge-detect flops reset high so held inputs make no event.
  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q      <= S_EMPTY;
      digits_q     <= '0;
      count_q      <= 4'd0;
      overflow_q   <= 1'b0;
      submit_q     <= 1'b0;
      accept_q     <= 1'b0;
      key_valid_q  <= 1'b1;
      submit_btn_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      submit_q     <= submit_d;
      accept_q     <= accept_d;
      key_valid_q  <= key_valid;
      submit_btn_q <= submit_btn;
    end
  end

  // Next-state: a submit edge wins over the count-derived state once the digit is stored.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY, S_ENTRY, S_FULL: begin
          if (submit_edge) begin
            state_d = S_HELD;
          end else if (count_d == 4'd0) begin
            state_d = S_EMPTY;
          end else if (count_d == MAX_CNT) begin
            state_d = S_FULL;
          end else begin
            state_d = S_ENTRY;
          end
        end
        S_HELD:  state_d = S_HELD;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Buffer update: clear dominates, HELD freezes everything for the comparison.
  always_comb begin
    digits_d   = digits_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    submit_d   = 1'b0;
    accept_d   = 1'b0;
    if (clear) begin
      digits_d   = '0;
      count_d    = 4'd0;
      overflow_d = 1'b0;
    end else if (state_q != S_HELD) begin
      if (press && (key_code <= CODE_MAX_DIGIT)) begin
        if (count_q < MAX_CNT) begin
          for (int i = 0; i < MAX_DIGITS; i++) begin
            digits_d[i*DIGIT_W +: DIGIT_W] = (count_q == 4'(i)) ? key_code
                                                                : digits_q[i*DIGIT_W +: DIGIT_W];
          end
          count_d  = count_q + 4'd1;
          accept_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
`ifdef KEY_BACKSPACE_EN
      else if (press && (key_code == CODE_BACKSPACE) && (count_q != 4'd0)) begin
        for (int i = 0; i < MAX_DIGITS; i++) begin
          digits_d[i*DIGIT_W +: DIGIT_W] = (count_q == 4'(i + 1)) ? {DIGIT_W{1'b0}}
                                                                  : digits_q[i*DIGIT_W +: DIGIT_W];
        end
        count_d  = count_q - 4'd1;
        accept_d = 1'b1;
      end
`endif
      else begin
        count_d = count_q;
      end
      submit_d = submit_edge;
    end else begin
      count_d = count_q;
    end
  end

  // Outputs; full is decoded straight from the stored count.
  always_comb begin
    digits     = digits_q;
    num_inputs = count_q;
    submit     = submit_q;
    key_accept = accept_q;
    overflow   = overflow_q;
    full       = (count_q == MAX_CNT);
  end

endmodule

// File: doc/key_entry_buffer.md
KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 10, giving the maximum number of stored digits (1..15).
REQ-002 The block SHALL have parameter DIGIT_W, default 4, giving the width of one digit code.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port system_reset, input, 1, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port key_valid, input, 1, the keypad key-down level; one rising edge is one press.
REQ-006 The block SHALL have port key_code, input, DIGIT_W, the code of the pressed key; 0..9 are digits.
REQ-007 The block SHALL have port submit_btn, input, 1, the submit button level.
REQ-008 The block SHALL have port clear, input, 1, the buffer-clear request from the controller's reset output.
REQ-009 The block SHALL have port digits, output, MAX_DIGITS*DIGIT_W, the packed buffer; the first entered digit is at [DIGIT_W-1:0].
REQ-010 The block SHALL have port num_inputs, output, 4, the count of stored digits.
REQ-011 The block SHALL have port submit, output, 1, a one-cycle submit pulse to the controller.
REQ-012 The block SHALL have port key_accept, output, 1, a one-cycle pulse when a key is applied to the buffer.
REQ-013 The block SHALL have port full, output, 1, high while num_inputs == MAX_DIGITS.
REQ-014 The block SHALL have port overflow, output, 1, a sticky flag set by a press while full.

Function
REQ-015 A press SHALL be detected when key_valid=1 and the registered key_valid from the previous cycle is 0; a held key SHALL count once.
REQ-016 A submit edge SHALL be detected when submit_btn=1 and the registered submit_btn from the previous cycle is 0.
REQ-017 The FSM SHALL have states EMPTY (count 0), ENTRY (0<count<MAX_DIGITS), FULL (count==MAX_DIGITS) and HELD (after submit, until clear).
REQ-018 A digit press (code<=9) in EMPTY or ENTRY SHALL write the code to slot num_inputs, increment num_inputs, and pulse key_accept, all at the detecting edge (latency 1 cycle); state SHALL move to ENTRY, or to FULL if the new count is MAX_DIGITS.
REQ-019 A press with code>9 (other than the REQ-029 code) SHALL be ignored: no write, no count change, no key_accept.
REQ-020 A digit press in FULL SHALL not write and SHALL set overflow; overflow SHALL remain set until clear or reset.
REQ-021 A submit edge in EMPTY, ENTRY or FULL SHALL pulse submit for exactly one cycle and move to HELD; submit with count 0 SHALL still pulse.
REQ-022 In HELD, presses and submit edges SHALL be ignored, and digits and num_inputs SHALL remain frozen for the controller's comparison.
REQ-023 clear SHALL, from any state, zero digits, num_inputs and overflow, and move to EMPTY at the next edge.
REQ-024 clear SHALL take priority over a same-cycle press or submit edge, which SHALL be discarded.
REQ-025 A same-cycle press and submit edge SHALL store the digit first, then pulse submit and move to HELD.
REQ-026 full SHALL be driven combinationally from num_inputs; num_inputs SHALL never exceed MAX_DIGITS.

Reset
REQ-027 On system_reset, digits=0, num_inputs=0, submit=0, key_accept=0, overflow=0 and state=EMPTY.
REQ-028 On system_reset, both edge-detect registers SHALL be set to 1, so a key or button held through reset produces no event.

Configuration
REQ-029 With macro KEY_BACKSPACE_EN defined, key_code 4'hB in ENTRY or FULL SHALL zero slot num_inputs-1, decrement num_inputs and pulse key_accept; in EMPTY it SHALL be ignored; overflow SHALL be unchanged.
REQ-030 Without KEY_BACKSPACE_EN, code 4'hB SHALL be treated as an invalid code per REQ-019.

Verification
REQ-031 Reset, then press 3,7,1 -> num_inputs=3, digits[11:0]=12'h173, three key_accept pulses, state ENTRY.
REQ-032 Hold key_valid for 5 cycles with code 5 -> one accept, num_inputs=1.
REQ-033 Press 10 digits, then an 11th -> full=1, num_inputs=10, overflow=1, slot 9 unchanged.
REQ-034 Press 4, raise submit_btn -> one submit pulse; further presses ignored; clear -> num_inputs=0, digits=0, overflow=0.
REQ-035 Assert clear in the same cycle as a press -> num_inputs=0, no key_accept.
REQ-036 With KEY_BACKSPACE_EN, press 2,9,B -> num_inputs=1, digits[7:4]=0; without the macro -> num_inputs=2.
